// File: rtl/axi_8bit_adder_ctrl_pkg.sv
// Shared types and default widths for the 8-bit AXI-stream adder controller
// and its neighbours.
package axi_8bit_adder_ctrl_pkg;

    localparam int unsigned DefaultW    = 8;
    localparam int unsigned DefaultCntW = 16;

    typedef enum logic {
        StCollect = 1'b0,
        StSend    = 1'b1
    } state_e;

endpackage

// File: rtl/axi_8bit_adder_ctrl_if.sv
// AXI-stream channel bundle (valid/ready/data) with producer and consumer views.
interface axi_8bit_adder_ctrl_if
    import axi_8bit_adder_ctrl_pkg::*;
#(
    parameter int unsigned DW = DefaultW
) ();

    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/axis_operand_slot.sv
// One-deep operand holding slot: captures a beat when enabled and empty, holds it
// until cleared, and strobes on the capture edge.
module axis_operand_slot
    import axi_8bit_adder_ctrl_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         valid,
    input  logic [W-1:0] data,
    output logic         ready,
    output logic [W-1:0] held_data,
    output logic         held,
    output logic         capture
);

    logic         held_q;
    logic [W-1:0] data_q;

    // Gated by rst_n so the channel reads not-ready throughout reset.
    assign ready     = rst_n & en & ~held_q;
    assign capture   = valid & ready;
    assign held      = held_q;
    assign held_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= 1'b0;
            data_q <= '0;
        end else if (capture) begin
            held_q <= 1'b1;
            data_q <= data;
        end else if (clr) begin
            held_q <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_8bit_adder_ctrl.sv
// Pairs operand A and B beats arriving in any order, registers their (W+1)-bit sum
// and holds it on the output stream until accepted; counts sums and carries.
module axi_8bit_adder_ctrl
    import axi_8bit_adder_ctrl_pkg::*;
#(
    parameter int unsigned W     = DefaultW,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_8bit_adder_ctrl_if.slave  s_a,
    axi_8bit_adder_ctrl_if.slave  s_b,
    axi_8bit_adder_ctrl_if.master m_axis,
    output logic [CNT_W-1:0]     sum_count,
    output logic [CNT_W-1:0]     carry_count
);

    state_e             state_q, state_d;
    logic               collect;
    logic               a_held, b_held;
    logic               a_cap, b_cap;
    logic [W-1:0]       a_q, b_q;
    logic [W-1:0]       a_op, b_op;
    logic [W:0]         sum_d;
    logic               pair_done;
    logic               out_hs;
    logic               m_valid_q;
    logic [W:0]         m_data_q;
    logic [CNT_W-1:0]   sum_count_q, carry_count_q;

    assign collect = (state_q == StCollect);
    assign out_hs  = m_valid_q & m_axis.ready;

    axis_operand_slot #(
        .W (W)
    ) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (collect),
        .clr       (out_hs),
        .valid     (s_a.valid),
        .data      (s_a.data),
        .ready     (s_a.ready),
        .held_data (a_q),
        .held      (a_held),
        .capture   (a_cap)
    );

    axis_operand_slot #(
        .W (W)
    ) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (collect),
        .clr       (out_hs),
        .valid     (s_b.valid),
        .data      (s_b.data),
        .ready     (s_b.ready),
        .held_data (b_q),
        .held      (b_held),
        .capture   (b_cap)
    );

    // An operand captured on the completing edge is not in its slot yet, so take
    // it straight from the bus.
    assign a_op      = a_cap ? s_a.data : a_q;
    assign b_op      = b_cap ? s_b.data : b_q;
    assign sum_d     = {1'b0, a_op} + {1'b0, b_op};
    assign pair_done = collect & (a_held | a_cap) & (b_held | b_cap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: if (pair_done) state_d = StSend;
            StSend:    if (out_hs)    state_d = StCollect;
            default:   state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else if (pair_done) begin
            m_valid_q <= 1'b1;
            m_data_q  <= sum_d;
        end else if (out_hs) begin
            m_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_count_q   <= '0;
            carry_count_q <= '0;
        end else if (out_hs) begin
            sum_count_q <= sum_count_q + CNT_W'(1);
            if (m_data_q[W]) begin
                carry_count_q <= carry_count_q + CNT_W'(1);
            end
        end
    end

    assign m_axis.valid = m_valid_q;
    assign m_axis.data  = m_data_q;
    assign sum_count    = sum_count_q;
    assign carry_count  = carry_count_q;

endmodule

// File: tb/tb_axi_8bit_adder_ctrl.sv
// Randomised self-checking bench for axi_8bit_adder_ctrl; expected sums and counter
// totals come from plain arithmetic on the stimulus.
module tb_axi_8bit_adder_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int NRAND = 100;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] sum_count, carry_count;

    int checks = 0;
    int errors = 0;
    int exp_sums = 0;
    int exp_carries = 0;

    axi_8bit_adder_ctrl_if #(.DW(W))     a_if ();
    axi_8bit_adder_ctrl_if #(.DW(W))     b_if ();
    axi_8bit_adder_ctrl_if #(.DW(W + 1)) m_if ();

    axi_8bit_adder_ctrl #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_a         (a_if),
        .s_b         (b_if),
        .m_axis      (m_if),
        .sum_count   (sum_count),
        .carry_count (carry_count)
    );

    always #5 clk = ~clk;

    // Presents one beat and holds valid until it is accepted or the budget runs out.
    task automatic drive_op(input bit is_b, input logic [W-1:0] d, input int budget,
                            output bit ok);
        ok = 1'b0;
        if (is_b) begin b_if.valid = 1'b1; b_if.data = d; end
        else      begin a_if.valid = 1'b1; a_if.data = d; end
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if ((is_b ? b_if.ready : a_if.ready) === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (is_b) b_if.valid = 1'b0;
        else      a_if.valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output logic [W:0] d, output bit ok);
        ok = 1'b0;
        d  = 'x;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (m_if.valid === 1'b1 && m_if.ready === 1'b1) begin
                d = m_if.data;
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W:0] d, output bit ok);
        bit oka, okb, oko;
        m_if.ready = 1'b1;
        fork
            drive_op(1'b0, a, 50, oka);
            drive_op(1'b1, b, 50, okb);
        join
        wait_out(20, d, oko);
        ok = oka & okb & oko;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_if.valid = 1'b1; a_if.data = 8'hAA;
        b_if.valid = 1'b1; b_if.data = 8'h55;
        m_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_if.ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b want 0", a_if.ready); end
        checks++; if (b_if.ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %b want 0", b_if.ready); end
        checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_if.valid); end
        checks++; if (m_if.data !== 9'h000) begin errors++; $display("FAIL reset_m_data: got %h want 000", m_if.data); end
        checks++; if (sum_count !== '0 || carry_count !== '0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", sum_count, carry_count); end
        a_if.valid = 1'b0;
        b_if.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (a_if.ready !== 1'b1 || b_if.ready !== 1'b1) begin errors++; $display("FAIL release_ready: got a=%b b=%b want 1/1", a_if.ready, b_if.ready); end
        checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL release_m_valid: got %b want 0", m_if.valid); end
    endtask

    task automatic test_same_edge;
        m_if.ready = 1'b1;
        a_if.valid = 1'b1; a_if.data = 8'h12;
        b_if.valid = 1'b1; b_if.data = 8'h34;
        @(posedge clk);
        #1;
        a_if.valid = 1'b0;
        b_if.valid = 1'b0;
        checks++; if (m_if.valid !== 1'b1 || m_if.data !== 9'h046) begin errors++; $display("FAIL same_edge_sum: got v=%b d=%h want 1/046", m_if.valid, m_if.data); end
        checks++; if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0) begin errors++; $display("FAIL same_edge_send_ready: got %b/%b want 0/0", a_if.ready, b_if.ready); end
        @(posedge clk);
        #1;
        exp_sums++;
        checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL same_edge_one_cycle: got valid %b want 0", m_if.valid); end
        checks++; if (sum_count !== CNT_W'(exp_sums) || carry_count !== CNT_W'(exp_carries)) begin errors++; $display("FAIL same_edge_counts: got %0d/%0d want %0d/%0d", sum_count, carry_count, CNT_W'(exp_sums), CNT_W'(exp_carries)); end
        checks++; if (a_if.ready !== 1'b1 || b_if.ready !== 1'b1) begin errors++; $display("FAIL same_edge_ready_back: got %b/%b want 1/1", a_if.ready, b_if.ready); end
    endtask

    task automatic test_carry_wait;
        bit ok;
        int bad = 0;
        m_if.ready = 1'b1;
        drive_op(1'b0, 8'hFF, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL carry_wait_a_accept: got timeout want handshake"); end
        repeat (40) begin
            @(negedge clk);
            if (a_if.ready !== 1'b0 || b_if.ready !== 1'b1 || m_if.valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL carry_wait_idle: got %0d bad cycles want 0", bad); end
        @(posedge clk);
        #1;
        drive_op(1'b1, 8'h01, 20, ok);
        checks++; if (!ok || m_if.valid !== 1'b1 || m_if.data !== 9'h100) begin errors++; $display("FAIL carry_wait_sum: got ok=%b v=%b d=%h want 1/1/100", ok, m_if.valid, m_if.data); end
        @(posedge clk);
        #1;
        exp_sums++;
        exp_carries++;
        checks++; if (m_if.valid !== 1'b0 || sum_count !== CNT_W'(exp_sums) || carry_count !== CNT_W'(exp_carries)) begin errors++; $display("FAIL carry_wait_counts: got v=%b %0d/%0d want 0 %0d/%0d", m_if.valid, sum_count, carry_count, CNT_W'(exp_sums), CNT_W'(exp_carries)); end
    endtask

    task automatic test_b_first_stall;
        bit ok;
        int bad = 0;
        m_if.ready = 1'b0;
        drive_op(1'b1, 8'h80, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b_first_accept: got timeout want handshake"); end
        repeat (25) begin
            @(negedge clk);
            if (a_if.ready !== 1'b1 || b_if.ready !== 1'b0 || m_if.valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b_first_wait: got %0d bad cycles want 0", bad); end
        @(posedge clk);
        #1;
        drive_op(1'b0, 8'h80, 20, ok);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (m_if.valid !== 1'b1 || m_if.data !== 9'h100 || a_if.ready !== 1'b0 || b_if.ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        checks++; if (!ok || bad != 0) begin errors++; $display("FAIL stall_hold: got ok=%b bad=%0d want 1/0", ok, bad); end
        m_if.ready = 1'b1;
        @(posedge clk);
        #1;
        exp_sums++;
        exp_carries++;
        checks++; if (m_if.valid !== 1'b0 || sum_count !== CNT_W'(exp_sums) || carry_count !== CNT_W'(exp_carries)) begin errors++; $display("FAIL stall_release: got v=%b %0d/%0d want 0 %0d/%0d", m_if.valid, sum_count, carry_count, CNT_W'(exp_sums), CNT_W'(exp_carries)); end
    endtask

    task automatic test_random;
        logic [W-1:0] ra [NRAND];
        logic [W-1:0] rb [NRAND];
        int a_to = 0, b_to = 0, got = 0, bad = 0;
        for (int i = 0; i < NRAND; i++) begin
            ra[i] = W'($urandom);
            rb[i] = W'($urandom);
        end
        fork
            begin
                bit ok;
                for (int i = 0; i < NRAND; i++) begin
                    repeat ($urandom_range(20, 60)) @(posedge clk);
                    #1;
                    drive_op(1'b0, ra[i], 3000, ok);
                    if (!ok) begin a_to++; break; end
                end
            end
            begin
                bit ok;
                for (int i = 0; i < NRAND; i++) begin
                    repeat ($urandom_range(20, 60)) @(posedge clk);
                    #1;
                    drive_op(1'b1, rb[i], 3000, ok);
                    if (!ok) begin b_to++; break; end
                end
            end
            begin
                int cyc = 0;
                int s;
                while (got < NRAND && cyc < 20000) begin
                    @(posedge clk);
                    #1;
                    m_if.ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    cyc++;
                    if (m_if.valid === 1'b1 && m_if.ready === 1'b1) begin
                        s = int'(ra[got]) + int'(rb[got]);
                        checks++;
                        if (m_if.data !== s[8:0]) begin
                            errors++;
                            $display("FAIL random_sum[%0d]: got %h want %h", got, m_if.data, s[8:0]);
                        end
                        exp_sums++;
                        if (s[8]) exp_carries++;
                        got++;
                    end
                end
            end
        join
        m_if.ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (got != NRAND || a_to != 0 || b_to != 0) begin errors++; $display("FAIL random_progress: got %0d sums a_to=%0d b_to=%0d want %0d/0/0", got, a_to, b_to, NRAND); end
        checks++; if (sum_count !== CNT_W'(exp_sums) || carry_count !== CNT_W'(exp_carries)) begin errors++; $display("FAIL random_counts: got %0d/%0d want %0d/%0d", sum_count, carry_count, CNT_W'(exp_sums), CNT_W'(exp_carries)); end
        bad = (m_if.valid !== 1'b0) ? 1 : 0;
        checks++; if (bad != 0) begin errors++; $display("FAIL random_drained: got valid %b want 0", m_if.valid); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        m_if.ready = 1'b1;
        drive_op(1'b0, 8'h55, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_reset_a_accept: got timeout want handshake"); end
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0 || m_if.valid !== 1'b0) begin errors++; $display("FAIL mid_reset_async: got a=%b b=%b v=%b want 0/0/0", a_if.ready, b_if.ready, m_if.valid); end
        checks++; if (sum_count !== '0 || carry_count !== '0) begin errors++; $display("FAIL mid_reset_counts: got %0d/%0d want 0/0", sum_count, carry_count); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_sums = 0;
        exp_carries = 0;
        @(posedge clk);
        #1;
        drive_op(1'b1, 8'h02, 20, ok);
        checks++; if (!ok || m_if.valid !== 1'b0 || a_if.ready !== 1'b1) begin errors++; $display("FAIL mid_reset_stale_a: got ok=%b v=%b a_ready=%b want 1/0/1", ok, m_if.valid, a_if.ready); end
        drive_op(1'b0, 8'h01, 20, ok);
        checks++; if (!ok || m_if.valid !== 1'b1 || m_if.data !== 9'h003) begin errors++; $display("FAIL mid_reset_sum: got ok=%b v=%b d=%h want 1/1/003", ok, m_if.valid, m_if.data); end
        @(posedge clk);
        #1;
        exp_sums++;
        checks++; if (sum_count !== CNT_W'(exp_sums) || carry_count !== CNT_W'(exp_carries)) begin errors++; $display("FAIL mid_reset_restart: got %0d/%0d want %0d/%0d", sum_count, carry_count, CNT_W'(exp_sums), CNT_W'(exp_carries)); end
    endtask

    task automatic test_wrap;
        bit ok;
        logic [W-1:0] a, b;
        logic [W:0] d;
        int s;
        int bad = 0;
        while (exp_sums < (1 << CNT_W)) begin
            a = W'($urandom);
            b = W'($urandom);
            s = int'(a) + int'(b);
            run_pair(a, b, d, ok);
            if (!ok || d !== s[8:0]) bad++;
            exp_sums++;
            if (s[8]) exp_carries++;
            if (exp_sums == (1 << CNT_W) - 1) begin
                checks++; if (sum_count !== CNT_W'(exp_sums)) begin errors++; $display("FAIL wrap_full: got %0d want %0d", sum_count, CNT_W'(exp_sums)); end
            end
            if (bad != 0) break;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_sums: got %0d bad transfers want 0", bad); end
        checks++; if (sum_count !== '0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", sum_count); end
        checks++; if (carry_count !== CNT_W'(exp_carries)) begin errors++; $display("FAIL wrap_carry: got %0d want %0d", carry_count, CNT_W'(exp_carries)); end
    endtask

    initial begin
        a_if.valid = 1'b0; a_if.data = '0;
        b_if.valid = 1'b0; b_if.data = '0;
        m_if.ready = 1'b0;
        test_reset();
        test_same_edge();
        test_carry_wait();
        test_b_first_stall();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
